// File: rtl/sample_feeder_if.sv
// sample_feeder_if: source/serializer side of the I2S sample FIFO.
interface sample_feeder_if #(parameter int DEPTH = 8, parameter int WIDTH = 16);
  localparam int LW = $clog2(DEPTH) + 1;
  logic [WIDTH-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic load;
  logic [WIDTH-1:0] out_data;
  logic out_chan;
  logic underrun;
  logic [7:0] underrun_count;
  logic [LW-1:0] level;
  logic empty;
  logic full;
  modport master (
    output in_data, in_valid, load,
    input in_ready, out_data, out_chan, underrun, underrun_count, level, empty, full
  );
  modport slave (
    input in_data, in_valid, load,
    output in_ready, out_data, out_chan, underrun, underrun_count, level, empty, full
  );
endinterface

// File: rtl/sample_feeder.sv
// sample_feeder: sample FIFO feeding the I2S serializer; registered output word,
// muted word on underrun, and an L/R tag that advances on every load.
module sample_feeder #(parameter int DEPTH = 8, parameter int WIDTH = 16) (
  input logic clk,
  input logic rst,
  sample_feeder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] depth_l = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] lvl;
  logic full, empty, push, pop;
  assign full = lvl == depth_l;
  assign empty = lvl == '0;
  assign push = bus.in_valid && !full;
  assign pop = bus.load && !empty;
  assign bus.full = full;
  assign bus.empty = empty;
  assign bus.in_ready = !full;
  assign bus.level = lvl;
  // storage is never reset; stale contents are unreachable once pointers clear
  always_ff @(posedge clk)
    if (push) mem[wp] <= bus.in_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      lvl <= '0;
      bus.out_data <= '0;
      bus.out_chan <= 1'b0;
      bus.underrun <= 1'b0;
      bus.underrun_count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      lvl <= (push && !pop) ? lvl + 1'b1 : (pop && !push) ? lvl - 1'b1 : lvl;
      bus.underrun <= bus.load && empty;
      if (bus.load) begin
        bus.out_data <= empty ? '0 : mem[rp];
        bus.out_chan <= !bus.out_chan;
      end
      if (bus.load && empty && bus.underrun_count != 8'hff) bus.underrun_count <= bus.underrun_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_sample_feeder.sv
// tb_sample_feeder: vector table plus queue-model scoreboard for sample_feeder.
module tb_sample_feeder;
  localparam int DEPTH = 8;
  localparam int WIDTH = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  typedef struct { logic [15:0] d; logic c; logic u; } exp_t;
  typedef struct { logic v; logic [15:0] d; logic ld; logic [3:0] lvl; logic full; } vec_t;
  exp_t sb[$];
  logic [15:0] mq[$];
  logic mchan = 1'b0;
  logic [15:0] mout = '0;
  int mcnt = 0;
  sample_feeder_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();
  sample_feeder #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_state();
    chk("level", 32'(bus.level), 32'(mq.size()));
    chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
    chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
    chk("in_ready", 32'(bus.in_ready), 32'(mq.size() != DEPTH));
    chk("underrun_count", 32'(bus.underrun_count), 32'(mcnt));
    chk("out_data_hold", 32'(bus.out_data), 32'(mout));
  endtask
  task automatic cycle(input logic v, input logic [15:0] d, input logic ld);
    int sz;
    exp_t e;
    sz = mq.size();
    bus.in_valid = v;
    bus.in_data = d;
    bus.load = ld;
    if (ld) begin
      mchan = !mchan;
      if (sz == 0) begin
        sb.push_back('{16'h0, mchan, 1'b1});
        if (mcnt != 255) mcnt++;
      end else sb.push_back('{mq.pop_front(), mchan, 1'b0});
    end
    if (v && sz < DEPTH) mq.push_back(d);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.load = 1'b0;
    if (ld) begin
      e = sb.pop_front();
      mout = e.d;
      chk("out_data", 32'(bus.out_data), 32'(e.d));
      chk("out_chan", 32'(bus.out_chan), 32'(e.c));
      chk("underrun", 32'(bus.underrun), 32'(e.u));
    end else chk("underrun_idle", 32'(bus.underrun), 32'h0);
    chk_state();
  endtask
  task automatic model_reset();
    mq.delete();
    sb.delete();
    mchan = 1'b0;
    mout = '0;
    mcnt = 0;
  endtask
  initial begin
    vec_t vt[9];
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.load = 1'b0;
    for (int i = 0; i < 9; i++) vt[i] = '{1'b1, 16'(i + 1), 1'b0, (i < 8) ? 4'(i + 1) : 4'd8, i >= 7};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_empty", 32'(bus.empty), 32'h1);
    chk("rst_full", 32'(bus.full), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_level", 32'(bus.level), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_out_chan", 32'(bus.out_chan), 32'h0);
    chk("rst_underrun", 32'(bus.underrun), 32'h0);
    chk("rst_count", 32'(bus.underrun_count), 32'h0);
    for (int i = 0; i < 9; i++) begin
      cycle(vt[i].v, vt[i].d, vt[i].ld);
      chk("fill_level", 32'(bus.level), 32'(vt[i].lvl));
      chk("fill_full", 32'(bus.full), 32'(vt[i].full));
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, '0, 1'b1);
      chk("drain_word", 32'(bus.out_data), 32'(i + 1));
      repeat (15) cycle(1'b0, '0, 1'b0);
    end
    chk("drain_empty", 32'(bus.empty), 32'h1);
    cycle(1'b0, '0, 1'b1);
    chk("ur_data", 32'(bus.out_data), 32'h0);
    chk("ur_pulse", 32'(bus.underrun), 32'h1);
    chk("ur_count1", 32'(bus.underrun_count), 32'h1);
    cycle(1'b0, '0, 1'b0);
    chk("ur_one_cycle", 32'(bus.underrun), 32'h0);
    cycle(1'b1, 16'hA5A5, 1'b1);
    chk("simul_empty_ur", 32'(bus.underrun), 32'h1);
    chk("simul_empty_lvl", 32'(bus.level), 32'h1);
    cycle(1'b0, '0, 1'b1);
    chk("simul_next", 32'(bus.out_data), 32'hA5A5);
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'(16'h0300 + i), 1'b0);
    cycle(1'b1, 16'hA5A5, 1'b1);
    chk("simul_lvl3", 32'(bus.level), 32'h3);
    repeat (3) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'(16'h0F00 + i), 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 16'(16'h1000 + i), 1'b1);
    chk("wrap_lvl", 32'(bus.level), 32'h4);
    repeat (4) cycle(1'b0, '0, 1'b1);
    chk("wrap_last", 32'(bus.out_data), 32'h1013);
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'(16'h2000 + i), 1'b0);
    cycle(1'b1, 16'hBEEF, 1'b1);
    chk("full_pop_only", 32'(bus.level), 32'h7);
    repeat (7) cycle(1'b0, '0, 1'b1);
    repeat (300) cycle(1'b0, '0, 1'b1);
    chk("sat_count", 32'(bus.underrun_count), 32'hFF);
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'(16'h3000 + i), 1'b0);
    cycle(1'b0, '0, 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_level", 32'(bus.level), 32'h0);
    chk("arst_empty", 32'(bus.empty), 32'h1);
    chk("arst_full", 32'(bus.full), 32'h0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("arst_out_data", 32'(bus.out_data), 32'h0);
    chk("arst_out_chan", 32'(bus.out_chan), 32'h0);
    chk("arst_underrun", 32'(bus.underrun), 32'h0);
    chk("arst_count", 32'(bus.underrun_count), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, '0, 1'b1);
    chk("post_rst_ur", 32'(bus.underrun), 32'h1);
    cycle(1'b0, '0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
